// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Brief    : Round-robin arbiter for three requesters sharing one 7-seg display
// Revision : 1.0
// ============================================================================
module seg_display_arbiter #(
  parameter int         HOLD_CYCLES  = 16,
  parameter logic [7:0] IDLE_PATTERN = 8'b00000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] req_i,
  input  logic [4:0] code0_i,
  input  logic [4:0] code1_i,
  input  logic [4:0] code2_i,
  output logic [2:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] owner_o,
  output logic [7:0] seg_o
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] counter, counter_nxt;
  logic [1:0] last_winner, last_nxt;
  logic [4:0] code_q, code_nxt;
  logic [7:0] seg_nxt;
  logic [2:0] grant_nxt;
  logic       done_nxt;
  logic [1:0] owner_nxt;

  logic [1:0] start;
  logic [2:0] cand;
  logic [1:0] winner;
  logic       found;
  logic [4:0] win_code;

  function automatic logic [7:0] decode(input logic [4:0] c);
    logic [7:0] s;
    case (c)
      5'd0:    s = 8'hFD;
      5'd1:    s = 8'hC1;
      5'd2:    s = 8'h6F;
      5'd3:    s = 8'hE7;
      5'd4:    s = 8'hD3;
      5'd5:    s = 8'hB7;
      5'd6:    s = 8'hBF;
      5'd7:    s = 8'hE1;
      5'd8:    s = 8'hFF;
      5'd9:    s = 8'hF7;
      default: s = (c[4:3] == 2'b10) ? (8'h80 >> c[2:0]) : 8'h00;
    endcase
    return s;
  endfunction

  // Scan from the highest offset down so the requester nearest the start wins.
  always_comb begin
    start  = (last_winner >= 2'd2) ? 2'd0 : last_winner + 2'd1;
    winner = 2'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req_i[cand[1:0]]) begin
        found  = 1'b1;
        winner = cand[1:0];
      end
    end
    case (winner)
      2'd0:    win_code = code0_i;
      2'd1:    win_code = code1_i;
      default: win_code = code2_i;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    last_nxt    = last_winner;
    code_nxt    = code_q;
    seg_nxt     = seg_o;
    owner_nxt   = owner_o;
    grant_nxt   = 3'b000;
    done_nxt    = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          seg_nxt   = IDLE_PATTERN;
          owner_nxt = 2'd3;
          if (found) begin
            state_nxt   = SHOW;
            grant_nxt   = 3'b001 << winner;
            code_nxt    = win_code;
            counter_nxt = HOLD_M1;
            last_nxt    = winner;
            owner_nxt   = winner;
            seg_nxt     = decode(win_code);
          end
        end
        SHOW: begin
          seg_nxt = decode(code_q);
          if (counter == 8'd0) begin
            state_nxt = GAP;
            seg_nxt   = 8'h00;
            owner_nxt = 2'd3;
          end else begin
            counter_nxt = counter - 8'd1;
          end
        end
        GAP: begin
          state_nxt = IDLE;
          seg_nxt   = IDLE_PATTERN;
          owner_nxt = 2'd3;
          done_nxt  = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          seg_nxt   = IDLE_PATTERN;
          owner_nxt = 2'd3;
        end
      endcase
    end
  end

  // Reset input is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      counter     <= 8'd0;
      last_winner <= 2'd2;
      code_q      <= 5'd0;
      seg_o       <= IDLE_PATTERN;
      grant_o     <= 3'b000;
      done_o      <= 1'b0;
      owner_o     <= 2'd3;
    end else begin
      state       <= state_nxt;
      counter     <= counter_nxt;
      last_winner <= last_nxt;
      code_q      <= code_nxt;
      seg_o       <= seg_nxt;
      grant_o     <= grant_nxt;
      done_o      <= done_nxt;
      owner_o     <= owner_nxt;
    end
  end

  assign busy_o = (state == SHOW) || (state == GAP);

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Brief    : Vector table plus scoreboard bench for seg_display_arbiter
// Revision : 1.0
// ============================================================================
module tb_seg_display_arbiter;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] req;
  logic [4:0] c0, c1, c2;
  logic [2:0] grant_o;
  logic       busy_o, done_o;
  logic [1:0] owner_o;
  logic [7:0] seg_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_PATTERN(8'b00000010)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_i(req),
    .code0_i(c0), .code1_i(c1), .code2_i(c2),
    .grant_o(grant_o), .busy_o(busy_o), .done_o(done_o),
    .owner_o(owner_o), .seg_o(seg_o)
  );

  typedef struct {
    logic [2:0] grant;
    logic [1:0] owner;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic [4:0] c0;
    logic [4:0] c1;
    logic [4:0] c2;
    logic [2:0] grant;
    logic [1:0] owner;
    logic [7:0] seg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [1:0] o, input logic [7:0] s);
    exp_t e;
    e.grant = g;
    e.owner = o;
    e.seg   = s;
    sb.push_back(e);
  endtask

  // Called one step after the grant edge; leaves the bench in the done_o cycle.
  task automatic do_show(input int freeze_at, input int freeze_len);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got grant %0h want queued expectation", grant_o);
      return;
    end
    e = sb.pop_front();
    chk("grant", grant_o, e.grant);
    chk("owner", owner_o, e.owner);
    chk("busy_show", busy_o, 1);
    for (int i = 0; i < HOLD; i++) begin
      if (i == freeze_at) begin
        ena = 1'b0;
        for (int f = 0; f < freeze_len; f++) begin
          tick;
          chk("frz_seg", seg_o, e.seg);
          chk("frz_busy", busy_o, 1);
          chk("frz_grant", grant_o, 0);
        end
        ena = 1'b1;
      end
      chk("show_seg", seg_o, e.seg);
      chk("show_done", done_o, 0);
      if (i > 0) chk("show_grant", grant_o, 0);
      tick;
    end
    chk("gap_seg", seg_o, 8'h00);
    chk("gap_busy", busy_o, 1);
    chk("gap_owner", owner_o, 3);
    chk("gap_done", done_o, 0);
    tick;
    chk("end_seg", seg_o, 8'h02);
    chk("end_done", done_o, 1);
    chk("end_busy", busy_o, 0);
    chk("end_owner", owner_o, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req, c0, c1, c2, grant, owner, seg
    vecs[0]  = '{3'b001, 5'd5,  5'd0,  5'd0,  3'b001, 2'd0, 8'hB7};
    vecs[1]  = '{3'b011, 5'd1,  5'd17, 5'd0,  3'b010, 2'd1, 8'h40};
    vecs[2]  = '{3'b011, 5'd9,  5'd3,  5'd0,  3'b001, 2'd0, 8'hF7};
    vecs[3]  = '{3'b100, 5'd0,  5'd0,  5'd23, 3'b100, 2'd2, 8'h01};
    vecs[4]  = '{3'b110, 5'd0,  5'd12, 5'd8,  3'b010, 2'd1, 8'h00};
    vecs[5]  = '{3'b101, 5'd16, 5'd0,  5'd7,  3'b100, 2'd2, 8'hE1};
    vecs[6]  = '{3'b111, 5'd2,  5'd4,  5'd6,  3'b001, 2'd0, 8'h6F};
    vecs[7]  = '{3'b100, 5'd0,  5'd0,  5'd31, 3'b100, 2'd2, 8'h00};
    vecs[8]  = '{3'b010, 5'd0,  5'd4,  5'd0,  3'b010, 2'd1, 8'hD3};
    vecs[9]  = '{3'b001, 5'd6,  5'd0,  5'd0,  3'b001, 2'd0, 8'hBF};
    vecs[10] = '{3'b001, 5'd8,  5'd0,  5'd0,  3'b001, 2'd0, 8'hFF};
    vecs[11] = '{3'b010, 5'd0,  5'd0,  5'd0,  3'b010, 2'd1, 8'hFD};
    vecs[12] = '{3'b011, 5'd20, 5'd9,  5'd0,  3'b001, 2'd0, 8'h08};

    rst_n = 1'b1;
    ena   = 1'b1;
    req   = 3'b000;
    c0 = 5'd0; c1 = 5'd0; c2 = 5'd0;
    tick;
    tick;
    chk("rst_seg", seg_o, 8'h02);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 3);
    chk("rst_grant", grant_o, 0);
    chk("rst_done", done_o, 0);

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("idle_seg", seg_o, 8'h02);
    chk("idle_busy", busy_o, 0);
    chk("idle_owner", owner_o, 3);

    foreach (vecs[v]) begin
      req = vecs[v].req;
      c0  = vecs[v].c0;
      c1  = vecs[v].c1;
      c2  = vecs[v].c2;
      push_exp(vecs[v].grant, vecs[v].owner, vecs[v].seg);
      tick;
      req = 3'b000;
      do_show(-1, 0);
    end

    // A pulse that drops before the edge is never sampled.
    req = 3'b001;
    #3;
    req = 3'b000;
    tick;
    chk("glitch_grant", grant_o, 0);
    chk("glitch_busy", busy_o, 0);

    // Disabled in IDLE: request is held off until ena returns.
    ena = 1'b0;
    req = 3'b001;
    c0  = 5'd5;
    tick;
    tick;
    chk("dis_grant", grant_o, 0);
    chk("dis_busy", busy_o, 0);
    chk("dis_seg", seg_o, 8'h02);
    ena = 1'b1;
    push_exp(3'b001, 2'd0, 8'hB7);
    tick;
    req = 3'b000;
    do_show(5, 5);

    // Reset in IDLE so pointer restarts at requester 0; then all three hold.
    rst_n = 1'b1;
    tick;
    rst_n = 1'b0;
    c0 = 5'd1; c1 = 5'd2; c2 = 5'd3;
    req = 3'b111;
    push_exp(3'b001, 2'd0, 8'hC1);
    push_exp(3'b010, 2'd1, 8'h6F);
    push_exp(3'b100, 2'd2, 8'hE7);
    push_exp(3'b001, 2'd0, 8'hC1);
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 3) req = 3'b000;
      do_show(-1, 0);
    end

    // Abort mid-SHOW with an asynchronous reset.
    c2  = 5'd5;
    req = 3'b100;
    tick;
    req = 3'b000;
    chk("abort_grant", grant_o, 3'b100);
    for (int i = 0; i < 4; i++) tick;
    chk("abort_pre_seg", seg_o, 8'hB7);
    rst_n = 1'b1;
    #1;
    chk("abort_seg", seg_o, 8'h02);
    chk("abort_busy", busy_o, 0);
    chk("abort_owner", owner_o, 3);
    chk("abort_done", done_o, 0);
    tick;
    chk("abort_done2", done_o, 0);
    rst_n = 1'b0;
    c1  = 5'd3;
    req = 3'b110;
    push_exp(3'b010, 2'd1, 8'hE7);
    tick;
    req = 3'b000;
    do_show(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
